// File: rtl/clock_pkg.sv
// Shared encodings, field limits and the wrap step used by the clock and stopwatch cores.
package clock_pkg;

  typedef enum logic [2:0] {
    ADJ_NORMAL   = 3'd0,
    ADJ_HOUR     = 3'd1,
    ADJ_MIN      = 3'd2,
    ADJ_ALM_HOUR = 3'd3,
    ADJ_ALM_MIN  = 3'd4
  } adj_mode_e;

  localparam logic [7:0] MAX_SEC  = 8'd59;
  localparam logic [7:0] MAX_MIN  = 8'd59;
  localparam logic [7:0] MAX_HOUR = 8'd23;

  // Step a field by one in either direction, wrapping between 0 and max_val.
  function automatic logic [7:0] wrap_step(input logic [7:0] val, input logic [7:0] max_val,
                                           input logic up);
    if (up) return (val == max_val) ? 8'd0 : val + 8'd1;
    return (val == 8'd0) ? max_val : val - 8'd1;
  endfunction

endpackage

// File: rtl/hms_counter.sv
// Seconds/minutes/hours chain: one-second advance with carries, per-field inc/dec without carry,
// and a seconds clear. The tick_* outputs show the time one advance would produce.
module hms_counter
  import clock_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       advance_i,
  input  logic       clear_sec_i,
  input  logic       adj_hour_i,
  input  logic       adj_min_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] hours_o,
  output logic [7:0] minutes_o,
  output logic [7:0] seconds_o,
  output logic [7:0] tick_hours_o,
  output logic [7:0] tick_minutes_o,
  output logic [7:0] tick_seconds_o
);

  logic [7:0] hours_q, minutes_q, seconds_q;
  logic [7:0] hours_d, minutes_d, seconds_d;
  logic       sec_wrap, min_wrap, step;

  assign sec_wrap = (seconds_q == MAX_SEC);
  assign min_wrap = (minutes_q == MAX_MIN);
  assign step     = inc_i ^ dec_i;

  assign tick_seconds_o = wrap_step(seconds_q, MAX_SEC, 1'b1);
  assign tick_minutes_o = sec_wrap ? wrap_step(minutes_q, MAX_MIN, 1'b1) : minutes_q;
  assign tick_hours_o   = (sec_wrap && min_wrap) ? wrap_step(hours_q, MAX_HOUR, 1'b1) : hours_q;

  // A field edit overrides an advance on that field; the clear overrides everything on seconds.
  always_comb begin
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    if (advance_i) begin
      hours_d   = tick_hours_o;
      minutes_d = tick_minutes_o;
      seconds_d = tick_seconds_o;
    end
    if (step && adj_hour_i) hours_d = wrap_step(hours_q, MAX_HOUR, inc_i);
    if (step && adj_min_i) minutes_d = wrap_step(minutes_q, MAX_MIN, inc_i);
    if (clear_sec_i) seconds_d = 8'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hours_q   <= 8'd0;
      minutes_q <= 8'd0;
      seconds_q <= 8'd0;
    end else begin
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
    end
  end

  assign hours_o   = hours_q;
  assign minutes_o = minutes_q;
  assign seconds_o = seconds_q;

endmodule

// File: rtl/clock_alarm_core.sv
// 24-hour clock with field adjustment, 12/24-hour display decode, hourly pre-chime,
// and an alarm with a fixed-length ring and minute-granular snooze.
module clock_alarm_core
  import clock_pkg::*;
#(
  parameter int CHIME_LEAD = 5,
  parameter int ALARM_DUR  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       inc,
  input  logic       dec,
  input  logic       fmt_12h,
  input  logic       alarm_en,
  input  logic       snooze,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic [7:0] disp_hours,
  output logic       pm,
  output logic [7:0] alarm_hours,
  output logic [7:0] alarm_minutes,
  output logic [2:0] adj_mode,
  output logic       chime,
  output logic       alarm_ring
);

  localparam logic [7:0] RING_LEN    = 8'(ALARM_DUR);
  localparam logic [7:0] SNOOZE_ADD  = 8'(SNOOZE_MIN);
  localparam logic [7:0] CHIME_START = 8'(60 - CHIME_LEAD);
  localparam bit         CHIME_ON    = (CHIME_LEAD != 0);

  adj_mode_e  mode_q;
  logic       runs_clock, advance, step, time_edit;
  logic [7:0] tick_h, tick_m, tick_s;

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      mode_q <= ADJ_NORMAL;
    end else if (mode) begin
      case (mode_q)
        ADJ_NORMAL:   mode_q <= ADJ_HOUR;
        ADJ_HOUR:     mode_q <= ADJ_MIN;
        ADJ_MIN:      mode_q <= ADJ_ALM_HOUR;
        ADJ_ALM_HOUR: mode_q <= ADJ_ALM_MIN;
        default:      mode_q <= ADJ_NORMAL;
      endcase
    end
  end

  // Editing the alarm fields must not stop time; only the time-edit modes freeze the clock.
  assign runs_clock = (mode_q == ADJ_NORMAL) || (mode_q == ADJ_ALM_HOUR) || (mode_q == ADJ_ALM_MIN);
  assign advance    = !en && runs_clock;
  assign step       = inc ^ dec;
  assign time_edit  = step && ((mode_q == ADJ_HOUR) || (mode_q == ADJ_MIN));

  hms_counter u_hms (
    .clk_i          (clk_1Hz),
    .rst_i          (rst),
    .advance_i      (advance),
    .clear_sec_i    (mode && (mode_q == ADJ_NORMAL)),
    .adj_hour_i     (mode_q == ADJ_HOUR),
    .adj_min_i      (mode_q == ADJ_MIN),
    .inc_i          (inc),
    .dec_i          (dec),
    .hours_o        (hours),
    .minutes_o      (minutes),
    .seconds_o      (seconds),
    .tick_hours_o   (tick_h),
    .tick_minutes_o (tick_m),
    .tick_seconds_o (tick_s)
  );

  logic [7:0] alarm_h_q, alarm_m_q;

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      alarm_h_q <= 8'd0;
      alarm_m_q <= 8'd0;
    end else begin
      if (step && (mode_q == ADJ_ALM_HOUR)) alarm_h_q <= wrap_step(alarm_h_q, MAX_HOUR, inc);
      if (step && (mode_q == ADJ_ALM_MIN)) alarm_m_q <= wrap_step(alarm_m_q, MAX_MIN, inc);
    end
  end

  logic       ring_q, ring_d, snz_pend_q, snz_pend_d;
  logic [7:0] ring_cnt_q, ring_cnt_d, snz_h_q, snz_h_d, snz_m_q, snz_m_d;
  logic       arrive, main_trig, snz_trig;
  logic [7:0] snz_sum, snz_h_calc, snz_m_calc;
  logic       snz_ovf;

  // "arrive" marks the advance that lands on a whole minute.
  assign arrive    = advance && (tick_s == 8'd0);
  assign main_trig = arrive && alarm_en && (mode_q != ADJ_ALM_MIN) &&
                     (tick_h == alarm_h_q) && (tick_m == alarm_m_q);
  assign snz_trig  = arrive && snz_pend_q && (tick_h == snz_h_q) && (tick_m == snz_m_q);

  assign snz_sum    = minutes + SNOOZE_ADD;
  assign snz_ovf    = (snz_sum > MAX_MIN);
  assign snz_m_calc = snz_ovf ? snz_sum - 8'd60 : snz_sum;
  assign snz_h_calc = snz_ovf ? wrap_step(hours, MAX_HOUR, 1'b1) : hours;

  always_comb begin
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    snz_pend_d = snz_pend_q;
    snz_h_d    = snz_h_q;
    snz_m_d    = snz_m_q;
    if (!alarm_en) begin
      ring_d     = 1'b0;
      ring_cnt_d = 8'd0;
      snz_pend_d = 1'b0;
    end else if (snooze && ring_q) begin
      ring_d     = 1'b0;
      ring_cnt_d = 8'd0;
      snz_pend_d = 1'b1;
      snz_h_d    = snz_h_calc;
      snz_m_d    = snz_m_calc;
    end else if (main_trig || snz_trig) begin
      ring_d     = 1'b1;
      ring_cnt_d = RING_LEN;
      if (snz_trig) snz_pend_d = 1'b0;
    end else if (ring_q) begin
      if (ring_cnt_q == 8'd1) begin
        ring_d     = 1'b0;
        ring_cnt_d = 8'd0;
      end else begin
        ring_cnt_d = ring_cnt_q - 8'd1;
      end
    end
    if (time_edit) snz_pend_d = 1'b0;
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      ring_q     <= 1'b0;
      ring_cnt_q <= 8'd0;
      snz_pend_q <= 1'b0;
      snz_h_q    <= 8'd0;
      snz_m_q    <= 8'd0;
    end else begin
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
      snz_pend_q <= snz_pend_d;
      snz_h_q    <= snz_h_d;
      snz_m_q    <= snz_m_d;
    end
  end

  always_comb begin
    disp_hours = hours;
    if (fmt_12h) begin
      if (hours == 8'd0) disp_hours = 8'd12;
      else if (hours > 8'd12) disp_hours = hours - 8'd12;
    end
  end

  assign pm            = fmt_12h && (hours >= 8'd12);
  assign chime         = CHIME_ON && runs_clock && (minutes == MAX_MIN) && (seconds >= CHIME_START);
  assign alarm_hours   = alarm_h_q;
  assign alarm_minutes = alarm_m_q;
  assign adj_mode      = mode_q;
  assign alarm_ring    = ring_q;

endmodule

// File: tb/tb_clock_alarm_core.sv
// Bench for clock_alarm_core: two instances (default and short-ring/no-chime parameters)
// compared every cycle against a seconds-of-day reference model, plus directed boundary checks.
module tb_clock_alarm_core;

  logic clk_1Hz, rst, en, mode, inc, dec, fmt_12h, alarm_en, snooze;

  logic [7:0] hours_a, minutes_a, seconds_a, disp_a, ah_a, am_a;
  logic [7:0] hours_b, minutes_b, seconds_b, disp_b, ah_b, am_b;
  logic [2:0] mode_a, mode_b;
  logic       pm_a, pm_b, chime_a, chime_b, ring_a, ring_b;

  int n_checks = 0;
  int n_errors = 0;

  clock_alarm_core u_dut (
    .clk_1Hz(clk_1Hz), .rst(rst), .en(en), .mode(mode), .inc(inc), .dec(dec),
    .fmt_12h(fmt_12h), .alarm_en(alarm_en), .snooze(snooze),
    .hours(hours_a), .minutes(minutes_a), .seconds(seconds_a), .disp_hours(disp_a),
    .pm(pm_a), .alarm_hours(ah_a), .alarm_minutes(am_a), .adj_mode(mode_a),
    .chime(chime_a), .alarm_ring(ring_a)
  );

  clock_alarm_core #(.CHIME_LEAD(0), .ALARM_DUR(3), .SNOOZE_MIN(1)) u_dut_short (
    .clk_1Hz(clk_1Hz), .rst(rst), .en(en), .mode(mode), .inc(inc), .dec(dec),
    .fmt_12h(fmt_12h), .alarm_en(alarm_en), .snooze(snooze),
    .hours(hours_b), .minutes(minutes_b), .seconds(seconds_b), .disp_hours(disp_b),
    .pm(pm_b), .alarm_hours(ah_b), .alarm_minutes(am_b), .adj_mode(mode_b),
    .chime(chime_b), .alarm_ring(ring_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_1Hz = 1'b0;
    forever #5 clk_1Hz = ~clk_1Hz;
  end

  // ---------------- reference model ----------------
  // t: seconds since midnight; tgt: snooze target as minute of day; rem: ring cycles left.
  typedef struct {
    int t;
    int mode;
    int ah;
    int am;
    int rem;
    bit pend;
    int tgt;
  } mdl_t;

  mdl_t m_a, m_b;

  function automatic mdl_t mdl_step(input mdl_t s, input int dur, input int snz_min,
                                    input bit en_v, input bit mode_v, input bit inc_v,
                                    input bit dec_v, input bit aen_v, input bit snz_v);
    mdl_t n;
    int   h, mi, sc, tick, dir;
    bit   adv, arrive, mtrig, strig;
    n    = s;
    h    = s.t / 3600;
    mi   = (s.t / 60) % 60;
    sc   = s.t % 60;
    adv  = !en_v && (s.mode == 0 || s.mode == 3 || s.mode == 4);
    tick = (s.t + 1) % 86400;
    if (adv) n.t = tick;
    if (inc_v != dec_v) begin
      dir = inc_v ? 1 : -1;
      case (s.mode)
        1: n.t = ((h + dir + 24) % 24) * 3600 + mi * 60 + sc;
        2: n.t = h * 3600 + ((mi + dir + 60) % 60) * 60 + sc;
        3: n.ah = (s.ah + dir + 24) % 24;
        4: n.am = (s.am + dir + 60) % 60;
        default: ;
      endcase
    end
    if (mode_v && s.mode == 0) n.t = n.t - (n.t % 60);
    arrive = adv && (tick % 60 == 0);
    mtrig  = arrive && aen_v && s.mode != 4 && (tick / 60 == s.ah * 60 + s.am);
    strig  = arrive && s.pend && (tick / 60 == s.tgt);
    if (!aen_v) begin
      n.rem  = 0;
      n.pend = 1'b0;
    end else if (snz_v && s.rem > 0) begin
      n.rem  = 0;
      n.pend = 1'b1;
      n.tgt  = (s.t / 60 + snz_min) % 1440;
    end else if (mtrig || strig) begin
      n.rem = dur;
      if (strig) n.pend = 1'b0;
    end else if (s.rem > 0) begin
      n.rem = s.rem - 1;
    end
    if (inc_v != dec_v && (s.mode == 1 || s.mode == 2)) n.pend = 1'b0;
    if (mode_v) n.mode = (s.mode + 1) % 5;
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string who, input mdl_t s, input int lead,
                           input logic [7:0] hrs, input logic [7:0] mins, input logic [7:0] secs,
                           input logic [7:0] dh, input logic pm_o, input logic [7:0] ah,
                           input logic [7:0] am, input logic [2:0] md, input logic ch,
                           input logic rg);
    int eh, em, es, edisp;
    bit epm, ech;
    eh    = s.t / 3600;
    em    = (s.t / 60) % 60;
    es    = s.t % 60;
    edisp = !fmt_12h ? eh : (eh == 0) ? 12 : (eh > 12) ? eh - 12 : eh;
    epm   = fmt_12h && eh >= 12;
    ech   = lead != 0 && (s.mode == 0 || s.mode == 3 || s.mode == 4) && em == 59 && es >= 60 - lead;
    check_eq({who, ".hours"}, hrs, eh);
    check_eq({who, ".minutes"}, mins, em);
    check_eq({who, ".seconds"}, secs, es);
    check_eq({who, ".disp_hours"}, dh, edisp);
    check_eq({who, ".pm"}, pm_o, epm);
    check_eq({who, ".alarm_hours"}, ah, s.ah);
    check_eq({who, ".alarm_minutes"}, am, s.am);
    check_eq({who, ".adj_mode"}, md, s.mode);
    check_eq({who, ".chime"}, ch, ech);
    check_eq({who, ".alarm_ring"}, rg, s.rem > 0);
  endtask

  task automatic check_all();
    check_dut("a", m_a, 5, hours_a, minutes_a, seconds_a, disp_a, pm_a, ah_a, am_a, mode_a,
              chime_a, ring_a);
    check_dut("b", m_b, 0, hours_b, minutes_b, seconds_b, disp_b, pm_b, ah_b, am_b, mode_b,
              chime_b, ring_b);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit m, input bit i, input bit d, input bit s);
    mode   = m;
    inc    = i;
    dec    = d;
    snooze = s;
    @(posedge clk_1Hz);
    m_a = mdl_step(m_a, 60, 5, en, m, i, d, alarm_en, s);
    m_b = mdl_step(m_b, 3, 1, en, m, i, d, alarm_en, s);
    #1;
    mode   = 1'b0;
    inc    = 1'b0;
    dec    = 1'b0;
    snooze = 1'b0;
    check_all();
  endtask

  function automatic int field_val(input mdl_t s, input int sel);
    case (sel)
      1: return s.t / 3600;
      2: return (s.t / 60) % 60;
      3: return s.ah;
      default: return s.am;
    endcase
  endfunction

  task automatic goto_mode(input int target);
    for (int k = 0; k < 5 && m_a.mode != target; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_field(input int sel, input int val);
    goto_mode(sel);
    for (int k = 0; k < 60 && field_val(m_a, sel) != val; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_clock(input int h, input int m);
    set_field(1, h);
    set_field(2, m);
    goto_mode(0);
  endtask

  task automatic set_alarm(input int h, input int m);
    set_field(3, h);
    set_field(4, m);
    goto_mode(0);
  endtask

  task automatic run_until(input int h, input int m, input int s);
    int target;
    target = h * 3600 + m * 60 + s;
    for (int k = 0; k < 4000 && m_a.t != target; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reach_time", {8'd0, hours_a, minutes_a, seconds_a}, (h << 16) | (m << 8) | s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; en = 1'b0; mode = 1'b0; inc = 1'b0; dec = 1'b0;
    fmt_12h = 1'b0; alarm_en = 1'b0; snooze = 1'b0;
    m_a = '{default: 0};
    m_b = '{default: 0};
    #1 rst = 1'b1;
    #1 check_all();
    @(negedge clk_1Hz) rst = 1'b0;

    // Asynchronous reset in the middle of a cycle.
    set_clock(10, 20);
    run_until(10, 20, 30);
    #2 rst = 1'b1;
    #1;
    m_a = '{default: 0};
    m_b = '{default: 0};
    check_all();
    check_eq("async_rst_minutes", minutes_a, 0);
    @(negedge clk_1Hz) rst = 1'b0;

    // Pre-chime window and 12-hour display across the hour.
    set_clock(12, 59);
    fmt_12h = 1'b1;
    run_until(12, 59, 53);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("chime_at_54", chime_a, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("chime_at_55", chime_a, 1'b1);
    check_eq("chime_lead0", chime_b, 1'b0);
    run_until(13, 0, 0);
    check_eq("chime_at_top", chime_a, 1'b0);
    check_eq("disp_13h", disp_a, 8'd1);
    check_eq("pm_13h", pm_a, 1'b1);
    fmt_12h = 1'b0;

    // Alarm at 07:00: long ring on instance a, three-cycle ring on instance b.
    set_alarm(7, 0);
    alarm_en = 1'b1;
    set_clock(6, 59);
    run_until(6, 59, 58);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ring_before", ring_a, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ring_rise_a", ring_a, 1'b1);
    check_eq("ring_rise_b", ring_b, 1'b1);
    run_until(7, 0, 2);
    check_eq("ring_b_last", ring_b, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ring_b_end", ring_b, 1'b0);
    run_until(7, 0, 59);
    check_eq("ring_a_last", ring_a, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ring_a_end", ring_a, 1'b0);

    // Snooze across midnight, then snooze cancelled by dropping alarm_en.
    set_alarm(23, 58);
    set_clock(23, 57);
    run_until(23, 57, 59);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ring_2358", ring_a, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("snooze_drop", ring_a, 1'b0);
    run_until(0, 2, 59);
    check_eq("snooze_wait", ring_a, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("snooze_rering", ring_a, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    alarm_en = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    alarm_en = 1'b1;
    run_until(0, 8, 0);
    check_eq("snooze_cancel", ring_a, 1'b0);

    // Minute wrap on decrement, inc+dec cancel, seconds clear on entering mode 1.
    set_field(2, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("dec_wrap_min", minutes_a, 8'd59);
    check_eq("dec_keeps_hour", hours_a, 8'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("inc_dec_cancel", minutes_a, 8'd59);
    goto_mode(0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("clear_sec", seconds_a, 8'd0);
    check_eq("mode_is_1", mode_a, 3'd1);

    // Pause holds time; alarm-hour edit keeps time running.
    set_field(1, 5);
    set_field(2, 0);
    en = 1'b1;
    goto_mode(0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("pause_hold", {8'd0, hours_a, minutes_a, seconds_a}, 32'h00050000);
    en = 1'b0;
    goto_mode(3);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("mode3_runs", seconds_a, 8'd4);
    goto_mode(0);

    // Randomized phase: alarm placed just ahead of the current time.
    set_alarm(m_a.t / 3600, ((m_a.t / 60) % 60 + 2) % 60);
    for (int c = 0; c < 1500; c++) begin
      en       = ($urandom_range(0, 9) == 0);
      fmt_12h  = $urandom_range(0, 1);
      alarm_en = ($urandom_range(0, 19) != 0);
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
